axi4_lite_req_arbiter: RTL and testbench
========================================

Name: axi4_lite_req_arbiter

Overview:
- Two-requester round-robin arbiter in front of the AXI4-Lite master's user command port (addr/write/wdata/transfer/ready).
- Serialises register-access requests from two independent clients onto the single master, one transaction at a time.
- Returns read data and a completion pulse to the granted client.
- Sits between control clients (e.g. CPU bridge, DMA config engine) and the AXI4-Lite master.

Parameters:
- ADDR_W, 4, address width (matches master addr).
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 256, watchdog limit in WAIT; used only with AXI_ARB_TIMEOUT_EN.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- req0_valid  in  1  client 0 request; held high until req0_done.
- req0_write  in  1  1=write, 0=read; stable while req0_valid.
- req0_addr  in  ADDR_W  client 0 address.
- req0_wdata  in  DATA_W  client 0 write data.
- req0_done  out  1  one-cycle completion pulse.
- req0_rdata  out  DATA_W  read data; valid with req0_done.
- req0_err  out  1  timeout flag; valid with req0_done.
- req1_valid, req1_write, req1_addr, req1_wdata, req1_done, req1_rdata, req1_err: same as client 0.
- addr  out  ADDR_W  to master.
- write  out  1  to master.
- wdata  out  DATA_W  to master.
- transfer  out  1  one-cycle start pulse to master.
- ready  in  1  master completion pulse.
- rdata  in  DATA_W  master read data; valid when ready=1.
- busy  out  1  high in any state other than IDLE.
- grant  out  1  index of the client currently owning the master.

Behaviour:
- Reset (async, ARESET=1): state=IDLE; all outputs 0 (addr, wdata, rdata regs, done, err, transfer, busy, grant); priority pointer=0 (client 0 preferred). Reset during any state aborts the transaction with no done pulse; the master is expected to be reset by the same reset.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any reqN_valid is high at the clock edge, pick the winner: the sole requester, or the pointer client if both are requesting.
  - Latch the winner's write/addr/wdata into the addr/write/wdata output regs and set grant.
  - Go to ISSUE.
- ISSUE: transfer=1 for exactly this one cycle; go to WAIT. addr/write/wdata stay stable from latch until DONE exits.
- WAIT:
  - ready is honoured only here; ready in any other state is ignored.
  - On ready=1: capture rdata (reads only; writes capture 0); go to DONE.
- DONE:
  - req<grant>_done=1 for one cycle with rdata/err valid; reqN_rdata holds its value until the next done for that client.
  - Pointer is set to ~grant (the other client gets priority next); go to IDLE.
- Latency: valid sampled at edge k → transfer high in cycle k+1 → done high in the cycle after the edge that samples ready. Minimum 4 cycles, valid-to-done.
- The client must deassert valid in the cycle after done or it is re-arbitrated as a new request. With both clients continuously requesting, grants strictly alternate 0,1,0,1.
- Changing the req fields of a non-granted client while it waits is allowed; values are sampled only at grant.
- busy=1 in ISSUE/WAIT/DONE.

Optional Feature:
- Macro: AXI_ARB_TIMEOUT_EN.
- With the macro: a counter clears on WAIT entry and increments each WAIT cycle. When the count reaches TIMEOUT_CYCLES without ready, go to DONE with err=1 and rdata=0; a late ready is then ignored.
- Without the macro: no counter, WAIT is unbounded, req0_err/req1_err tied 0.

Test Plan:
- Single write: req0 write addr=4'h4 wdata=32'h2, master ready 3 cycles after transfer → one transfer pulse with addr=4'h4/write=1/wdata=2; req0_done 1 cycle later, req0_err=0, req1_done never.
- Single read: req1 read addr=4'h8, master rdata=32'hDEADBEEF with ready → req1_done pulse with req1_rdata=32'hDEADBEEF, grant=1 during the transaction.
- Contention: both valid in the same cycle after reset → client 0 served first, then client 1; with both held continuously for 4 transactions the grant order is 0,1,0,1.
- Spurious ready: ready pulsed in IDLE and in ISSUE → ignored; no done until ready arrives in WAIT.
- Mid-transaction reset: assert ARESET during WAIT → all outputs 0 immediately; after release, the pending req1 is granted first only if req0 is idle (pointer=0).
- Timeout (AXI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): req0 read with ready never asserted → req0_done with req0_err=1, rdata=0; FSM returns to IDLE and serves req1 next.

Source files
------------

// File: rtl/axi4_lite_req_arbiter.sv
// Two-client round-robin arbiter in front of an AXI4-Lite master command port.
// Optional WAIT watchdog enabled by defining AXI_ARB_TIMEOUT_EN.
module axi4_lite_req_arbiter #(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_err,
  output logic [ADDR_W-1:0] addr,
  output logic              write,
  output logic [DATA_W-1:0] wdata,
  output logic              transfer,
  input  logic              ready,
  input  logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              grant
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state_q;
  logic              ptr_q;
  logic              grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic              transfer_q;
  logic              busy_q;
  logic              done0_q;
  logic              done1_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              err0_q;
  logic              err1_q;

  logic              any_req;
  logic              win_d;
  logic              fin_d;
  logic              fin_err_d;
  logic [DATA_W-1:0] fin_data_d;
  logic              tmo_d;

`ifdef AXI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  assign tmo_d = (state_q == S_WAIT) &&
                 (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: cleared while issuing, counts every WAIT cycle.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cnt_q <= '0;
    end else if (state_q == S_ISSUE) begin
      cnt_q <= '0;
    end else if (state_q == S_WAIT && !tmo_d) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  logic unused_tmo;

  assign tmo_d      = 1'b0;
  assign unused_tmo = (TIMEOUT_CYCLES > 0);
`endif

  // Winner selection and completion data for the current transaction.
  always_comb begin
    any_req    = req0_valid | req1_valid;
    win_d      = 1'b0;
    if (req0_valid && req1_valid) begin
      win_d = ptr_q;
    end else if (req1_valid) begin
      win_d = 1'b1;
    end
    fin_d      = (state_q == S_WAIT) && (ready || tmo_d);
    fin_err_d  = tmo_d && !ready;
    fin_data_d = (ready && !write_q) ? rdata : '0;
  end

  // Main arbiter FSM with registered outputs.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q    <= S_IDLE;
      ptr_q      <= 1'b0;
      grant_q    <= 1'b0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      transfer_q <= 1'b0;
      busy_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
    end else begin
      transfer_q <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (any_req) begin
            grant_q    <= win_d;
            write_q    <= win_d ? req1_write : req0_write;
            addr_q     <= win_d ? req1_addr  : req0_addr;
            wdata_q    <= win_d ? req1_wdata : req0_wdata;
            transfer_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (fin_d) begin
            if (grant_q) begin
              done1_q  <= 1'b1;
              rdata1_q <= fin_data_d;
              err1_q   <= fin_err_d;
            end else begin
              done0_q  <= 1'b1;
              rdata0_q <= fin_data_d;
              err0_q   <= fin_err_d;
            end
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          ptr_q   <= ~grant_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign addr       = addr_q;
  assign write      = write_q;
  assign wdata      = wdata_q;
  assign transfer   = transfer_q;
  assign busy       = busy_q;
  assign grant      = grant_q;
  assign req0_done  = done0_q;
  assign req0_rdata = rdata0_q;
  assign req0_err   = err0_q;
  assign req1_done  = done1_q;
  assign req1_rdata = rdata1_q;
  assign req1_err   = err1_q;

endmodule

// File: tb/tb_axi4_lite_req_arbiter.sv
// Directed bench for axi4_lite_req_arbiter: cycle tables plus
// hand-written reset and timeout sequences.
module tb_axi4_lite_req_arbiter;

  typedef struct packed {
    logic        v0;
    logic        w0;
    logic [3:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic        w1;
    logic [3:0]  a1;
    logic [31:0] d1;
    logic        rdy;
    logic [31:0] rd;
  } in_t;

  typedef struct packed {
    logic        tr;
    logic        bsy;
    logic        gnt;
    logic        dn0;
    logic        dn1;
    logic        er0;
    logic        er1;
    logic [3:0]  addr;
    logic        wr;
    logic [31:0] wd;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } out_t;

  typedef struct {
    string nm;
    in_t   i;
    out_t  o;
  } vec_t;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        req0_valid, req0_write, req0_done, req0_err;
  logic [3:0]  req0_addr;
  logic [31:0] req0_wdata, req0_rdata;
  logic        req1_valid, req1_write, req1_done, req1_err;
  logic [3:0]  req1_addr;
  logic [31:0] req1_wdata, req1_rdata;
  logic [3:0]  addr;
  logic        write, transfer, ready, busy, grant;
  logic [31:0] wdata, rdata;

  int checks   = 0;
  int failures = 0;

  always #5 ACLK = ~ACLK;

  axi4_lite_req_arbiter #(
    .ADDR_W(4),
    .DATA_W(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .req0_valid(req0_valid),
    .req0_write(req0_write),
    .req0_addr(req0_addr),
    .req0_wdata(req0_wdata),
    .req0_done(req0_done),
    .req0_rdata(req0_rdata),
    .req0_err(req0_err),
    .req1_valid(req1_valid),
    .req1_write(req1_write),
    .req1_addr(req1_addr),
    .req1_wdata(req1_wdata),
    .req1_done(req1_done),
    .req1_rdata(req1_rdata),
    .req1_err(req1_err),
    .addr(addr),
    .write(write),
    .wdata(wdata),
    .transfer(transfer),
    .ready(ready),
    .rdata(rdata),
    .busy(busy),
    .grant(grant)
  );

  function automatic in_t fi(int v0, int w0, int a0, int d0,
                             int v1, int w1, int a1, int d1,
                             int rdy, int rd);
    in_t r;
    r.v0  = v0[0];
    r.w0  = w0[0];
    r.a0  = a0[3:0];
    r.d0  = d0;
    r.v1  = v1[0];
    r.w1  = w1[0];
    r.a1  = a1[3:0];
    r.d1  = d1;
    r.rdy = rdy[0];
    r.rd  = rd;
    return r;
  endfunction

  function automatic out_t fo(int tr, int bsy, int gnt, int dn0,
                              int dn1, int er0, int er1, int ad,
                              int wr, int wd, int rd0, int rd1);
    out_t r;
    r.tr   = tr[0];
    r.bsy  = bsy[0];
    r.gnt  = gnt[0];
    r.dn0  = dn0[0];
    r.dn1  = dn1[0];
    r.er0  = er0[0];
    r.er1  = er1[0];
    r.addr = ad[3:0];
    r.wr   = wr[0];
    r.wd   = wd;
    r.rd0  = rd0;
    r.rd1  = rd1;
    return r;
  endfunction

  function automatic out_t cur();
    out_t r;
    r.tr   = transfer;
    r.bsy  = busy;
    r.gnt  = grant;
    r.dn0  = req0_done;
    r.dn1  = req1_done;
    r.er0  = req0_err;
    r.er1  = req1_err;
    r.addr = addr;
    r.wr   = write;
    r.wd   = wdata;
    r.rd0  = req0_rdata;
    r.rd1  = req1_rdata;
    return r;
  endfunction

  task automatic drive(input in_t i);
    req0_valid = i.v0;
    req0_write = i.w0;
    req0_addr  = i.a0;
    req0_wdata = i.d0;
    req1_valid = i.v1;
    req1_write = i.w1;
    req1_addr  = i.a1;
    req1_wdata = i.d1;
    ready      = i.rdy;
    rdata      = i.rd;
  endtask

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic wait_done(input int c, input int lim, output int n);
    n = -1;
    for (int k = 1; k <= lim; k++) begin
      @(negedge ACLK);
      if ((c == 0) ? req0_done : req1_done) begin
        n = k;
        break;
      end
    end
  endtask

  vec_t vt[$];
  in_t  z;
  in_t  b;
  int   n;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    z = fi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Single write from client 0, ready three cycles after transfer.
    vt.push_back('{"wr_idle", fi(1,1,4,2,0,0,0,0,0,0),
      fo(0,0,0,0,0,0,0,0,0,0,0,0)});
    vt.push_back('{"wr_issue", fi(1,1,4,2,0,0,0,0,0,0),
      fo(1,1,0,0,0,0,0,4,1,2,0,0)});
    vt.push_back('{"wr_wait1", fi(1,1,4,2,0,0,0,0,0,0),
      fo(0,1,0,0,0,0,0,4,1,2,0,0)});
    vt.push_back('{"wr_wait2", fi(1,1,4,2,0,0,0,0,0,0),
      fo(0,1,0,0,0,0,0,4,1,2,0,0)});
    vt.push_back('{"wr_wait3", fi(1,1,4,2,0,0,0,0,1,'h55),
      fo(0,1,0,0,0,0,0,4,1,2,0,0)});
    vt.push_back('{"wr_done", z,
      fo(0,1,0,1,0,0,0,4,1,2,0,0)});
    vt.push_back('{"wr_back", z,
      fo(0,0,0,0,0,0,0,4,1,2,0,0)});
    // Single read from client 1 at minimum latency.
    vt.push_back('{"rd_idle", fi(0,0,0,0,1,0,8,0,0,0),
      fo(0,0,0,0,0,0,0,4,1,2,0,0)});
    vt.push_back('{"rd_issue", fi(0,0,0,0,1,0,8,0,0,0),
      fo(1,1,1,0,0,0,0,8,0,0,0,0)});
    vt.push_back('{"rd_wait", fi(0,0,0,0,1,0,8,0,1,'hDEADBEEF),
      fo(0,1,1,0,0,0,0,8,0,0,0,0)});
    vt.push_back('{"rd_done", z,
      fo(0,1,1,0,1,0,0,8,0,0,0,'hDEADBEEF)});
    vt.push_back('{"rd_back", z,
      fo(0,0,1,0,0,0,0,8,0,0,0,'hDEADBEEF)});
    // Contention, spurious ready in IDLE/ISSUE, alternation 0,1,0,1.
    b = fi(1,0,1,0,1,1,2,'h11,1,'hBAD);
    vt.push_back('{"ct_idle_spur", b,
      fo(0,0,1,0,0,0,0,8,0,0,0,'hDEADBEEF)});
    vt.push_back('{"ct_g0_issue_spur", b,
      fo(1,1,0,0,0,0,0,1,0,0,0,'hDEADBEEF)});
    b.rdy = 1'b0;
    vt.push_back('{"ct_g0_wait", b,
      fo(0,1,0,0,0,0,0,1,0,0,0,'hDEADBEEF)});
    b.rdy = 1'b1;
    b.rd  = 32'hA5A5A5A5;
    vt.push_back('{"ct_g0_wait_nodone", b,
      fo(0,1,0,0,0,0,0,1,0,0,0,'hDEADBEEF)});
    b.rdy = 1'b0;
    vt.push_back('{"ct_g0_done", b,
      fo(0,1,0,1,0,0,0,1,0,0,'hA5A5A5A5,'hDEADBEEF)});
    vt.push_back('{"ct_idle2", b,
      fo(0,0,0,0,0,0,0,1,0,0,'hA5A5A5A5,'hDEADBEEF)});
    vt.push_back('{"ct_g1_issue", b,
      fo(1,1,1,0,0,0,0,2,1,'h11,'hA5A5A5A5,'hDEADBEEF)});
    b.rdy = 1'b1;
    b.rd  = 32'h77;
    vt.push_back('{"ct_g1_wait", b,
      fo(0,1,1,0,0,0,0,2,1,'h11,'hA5A5A5A5,'hDEADBEEF)});
    b.rdy = 1'b0;
    vt.push_back('{"ct_g1_done", b,
      fo(0,1,1,0,1,0,0,2,1,'h11,'hA5A5A5A5,0)});
    vt.push_back('{"ct_idle3", b,
      fo(0,0,1,0,0,0,0,2,1,'h11,'hA5A5A5A5,0)});
    vt.push_back('{"ct_g0b_issue", b,
      fo(1,1,0,0,0,0,0,1,0,0,'hA5A5A5A5,0)});
    b.rdy = 1'b1;
    b.rd  = 32'h12345678;
    vt.push_back('{"ct_g0b_wait", b,
      fo(0,1,0,0,0,0,0,1,0,0,'hA5A5A5A5,0)});
    vt.push_back('{"ct_g0b_done", fi(0,0,0,0,1,1,2,'h11,0,0),
      fo(0,1,0,1,0,0,0,1,0,0,'h12345678,0)});
    vt.push_back('{"ct_idle4", fi(0,0,0,0,1,1,2,'h11,0,0),
      fo(0,0,0,0,0,0,0,1,0,0,'h12345678,0)});
    vt.push_back('{"ct_g1b_issue", fi(0,0,0,0,1,1,2,'h11,0,0),
      fo(1,1,1,0,0,0,0,2,1,'h11,'h12345678,0)});
    vt.push_back('{"ct_g1b_wait", fi(0,0,0,0,1,1,2,'h11,1,0),
      fo(0,1,1,0,0,0,0,2,1,'h11,'h12345678,0)});
    vt.push_back('{"ct_g1b_done", z,
      fo(0,1,1,0,1,0,0,2,1,'h11,'h12345678,0)});
    vt.push_back('{"ct_end", z,
      fo(0,0,1,0,0,0,0,2,1,'h11,'h12345678,0)});

    ARESET = 1'b1;
    drive(z);
    repeat (2) @(negedge ACLK);
    chk("reset_state", 128'(cur()), 128'(0));
    ARESET = 1'b0;

    foreach (vt[k]) begin
      @(negedge ACLK);
      chk(vt[k].nm, 128'(cur()), 128'(vt[k].o));
      drive(vt[k].i);
    end

    // Client 0 read completes, leaving priority with client 1.
    @(negedge ACLK);
    drive(fi(1,0,5,0,0,0,0,0,1,'hCAFE0001));
    wait_done(0, 20, n);
    chk("pre_rst_done0", 128'(n > 0), 128'(1));
    chk("pre_rst_rd0", 128'(req0_rdata), 128'(32'hCAFE0001));
    drive(z);
    @(negedge ACLK);
    drive(fi(1,0,7,0,0,0,0,0,0,0));
    @(negedge ACLK);
    chk("mr_issue", 128'({transfer, grant, addr}), 128'({1'b1, 1'b0, 4'h7}));
    drive(fi(1,0,7,0,1,0,9,0,0,0));
    @(negedge ACLK);
    chk("mr_wait", 128'({busy, transfer}), 128'({1'b1, 1'b0}));
    #1 ARESET = 1'b1;
    #1 chk("mr_async_clear", 128'(cur()), 128'(0));
    @(negedge ACLK);
    chk("mr_held_clear", 128'(cur()), 128'(0));
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("mr_ptr_reset", 128'({transfer, grant, addr}), 128'({1'b1, 1'b0, 4'h7}));
    ready = 1'b1;
    rdata = 32'h0BADF00D;
    wait_done(0, 20, n);
    chk("mr_done0", 128'({n > 0, req0_rdata}), 128'({1'b1, 32'h0BADF00D}));
    req0_valid = 1'b0;
    rdata      = 32'h44;
    wait_done(1, 20, n);
    chk("mr_done1", 128'({n > 0, req1_rdata, req1_err}), 128'({1'b1, 32'h44, 1'b0}));
    drive(z);
    @(negedge ACLK);

`ifdef AXI_ARB_TIMEOUT_EN
    // Client 0 read that the master never answers.
    drive(fi(1,0,6,0,1,0,3,0,0,0));
    @(negedge ACLK);
    chk("to_issue", 128'({transfer, grant}), 128'({1'b1, 1'b0}));
    wait_done(0, 30, n);
    chk("to_latency", 128'(n), 128'(9));
    chk("to_err_rdata", 128'({req0_err, req0_rdata}), 128'({1'b1, 32'h0}));
    req0_valid = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    chk("to_next_g1", 128'({transfer, grant, addr}), 128'({1'b1, 1'b1, 4'h3}));
    ready = 1'b1;
    rdata = 32'h66;
    wait_done(1, 20, n);
    chk("to_done1", 128'({n > 0, req1_err, req1_rdata}), 128'({1'b1, 1'b0, 32'h66}));
    drive(z);
    @(negedge ACLK);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
